// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared constants, pipeline stage type and pc helper for the
// LC3 instruction-memory responder and its protocol checker.
package imem_fetch_pkg;

   localparam int IMEM_WORD_W = 16;
   localparam logic [IMEM_WORD_W-1:0] IMEM_DEFAULT_BASE = 16'h3000;

   // One slot of the read pipeline: response word plus the npc that rode along.
   typedef struct packed {
      logic                   valid;
      logic [IMEM_WORD_W-1:0] data;
      logic [IMEM_WORD_W-1:0] npc;
   } imem_pipe_stage_t;

   // Sequential successor of a fetch address; wraps 16'hFFFF -> 16'h0000.
   function automatic logic [IMEM_WORD_W-1:0] next_pc(input logic [IMEM_WORD_W-1:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/imem_fetch_checker.sv
// imem_fetch_checker: address decode, fetch counter and sticky protocol flags
// (address range, npc == pc+1, sequential pc unless a flush intervened).
module imem_fetch_checker
   import imem_fetch_pkg::*;
#(
   parameter logic [IMEM_WORD_W-1:0] BASE_ADDR = IMEM_DEFAULT_BASE,
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req,
   input  logic                   flush,
   input  logic [IMEM_WORD_W-1:0] pc,
   input  logic [IMEM_WORD_W-1:0] npc,
   output logic [AW-1:0]          rd_idx,
   output logic                   out_of_range,
   output logic [IMEM_WORD_W-1:0] fetch_count,
   output logic                   addr_err,
   output logic                   npc_err,
   output logic                   seq_err
);

   logic [IMEM_WORD_W-1:0] offset;
   logic [IMEM_WORD_W-1:0] count_reg;
   logic [IMEM_WORD_W-1:0] prev_pc_reg;
   logic                   prev_valid_reg;
   logic                   addr_err_reg;
   logic                   npc_err_reg;
   logic                   seq_err_reg;
   logic                   seq_break;

   // The full 16-bit offset decides range; only its low bits index the array.
   assign offset       = pc - BASE_ADDR;
   assign rd_idx       = offset[AW-1:0];
   assign out_of_range = (offset >= 16'(DEPTH));

   // A request on a flush edge starts a fresh sequence, so it is never a break.
   assign seq_break = prev_valid_reg && !flush && (pc != next_pc(prev_pc_reg));

   // Count accepted requests, track the previous pc and latch the sticky flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg      <= '0;
         prev_pc_reg    <= '0;
         prev_valid_reg <= 1'b0;
         addr_err_reg   <= 1'b0;
         npc_err_reg    <= 1'b0;
         seq_err_reg    <= 1'b0;
      end else if (req) begin
         count_reg      <= count_reg + 16'd1;
         prev_pc_reg    <= pc;
         prev_valid_reg <= 1'b1;
         if (out_of_range)
            addr_err_reg <= 1'b1;
         if (npc != next_pc(pc))
            npc_err_reg <= 1'b1;
         if (seq_break)
            seq_err_reg <= 1'b1;
      end else if (flush) begin
         prev_valid_reg <= 1'b0;
      end
   end

   assign fetch_count = count_reg;
   assign addr_err    = addr_err_reg;
   assign npc_err     = npc_err_reg;
   assign seq_err     = seq_err_reg;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: LC3 instruction memory model on the fetch_out bus with a
// READ_LAT-deep read pipeline, flush support and protocol checking.
// Optional build macro IMEM_PARITY_EN adds per-word even parity, the
// parity_inject input and the sticky parity_err output.
module imem_fetch_responder
   import imem_fetch_pkg::*;
#(
   parameter logic [IMEM_WORD_W-1:0] BASE_ADDR = IMEM_DEFAULT_BASE,
   parameter int DEPTH = 256,
   parameter int READ_LAT = 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable_fetch,
   input  logic [IMEM_WORD_W-1:0] pc,
   input  logic [IMEM_WORD_W-1:0] npc,
   input  logic                   Imem_rd,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [IMEM_WORD_W-1:0] wr_data,
`ifdef IMEM_PARITY_EN
   input  logic                   parity_inject,
   output logic                   parity_err,
`endif
   output logic                   instr_valid,
   output logic [IMEM_WORD_W-1:0] instr_dout,
   output logic [IMEM_WORD_W-1:0] npc_out,
   output logic [IMEM_WORD_W-1:0] fetch_count,
   output logic                   addr_err,
   output logic                   npc_err,
   output logic                   seq_err
);

   logic                   req;
   logic [AW-1:0]          rd_idx;
   logic                   out_of_range;

   logic [IMEM_WORD_W-1:0] mem_reg [DEPTH];
   logic [IMEM_WORD_W-1:0] rd_word_reg;

   // Stage 0 control; its data comes straight from the registered array read.
   logic                   s0_valid_reg;
   logic                   s0_zero_reg;
   logic [IMEM_WORD_W-1:0] s0_npc_reg;

   imem_pipe_stage_t       pipe [READ_LAT];

   assign req = enable_fetch & Imem_rd;

   imem_fetch_checker #(
      .BASE_ADDR (BASE_ADDR),
      .DEPTH     (DEPTH)
   ) u_checker (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .flush        (flush),
      .pc           (pc),
      .npc          (npc),
      .rd_idx       (rd_idx),
      .out_of_range (out_of_range),
      .fetch_count  (fetch_count),
      .addr_err     (addr_err),
      .npc_err      (npc_err),
      .seq_err      (seq_err)
   );

   // Block RAM: preload write and read-first registered read on each request.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem_reg[wr_addr] <= wr_data;
      if (req)
         rd_word_reg <= mem_reg[rd_idx];
   end

   // First pipeline stage; s0_zero_reg masks the array word after reset and for
   // out-of-range requests, and only a new request changes the held contents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s0_valid_reg <= 1'b0;
         s0_zero_reg  <= 1'b1;
         s0_npc_reg   <= '0;
      end else begin
         s0_valid_reg <= req;
         if (req) begin
            s0_zero_reg <= out_of_range;
            s0_npc_reg  <= npc;
         end
      end
   end

   assign pipe[0].valid = s0_valid_reg;
   assign pipe[0].data  = s0_zero_reg ? 16'h0000 : rd_word_reg;
   assign pipe[0].npc   = s0_npc_reg;

`ifdef IMEM_PARITY_EN
   logic                par_mem_reg [DEPTH];
   logic                rd_par_reg;
   logic [READ_LAT-1:0] bad;
   logic                parity_err_reg;

   // Parity RAM alongside the data array; inject flips the stored bit.
   always_ff @(posedge clock) begin
      if (wr_en)
         par_mem_reg[wr_addr] <= (^wr_data) ^ parity_inject;
      if (req)
         rd_par_reg <= par_mem_reg[rd_idx];
   end

   // Out-of-range reads return a synthetic zero and carry no stored parity.
   assign bad[0] = !s0_zero_reg && ((^rd_word_reg) != rd_par_reg);
`endif

   // Later stages move a word forward only when it is live; flush kills them.
   genvar gi;
   generate
      for (gi = 1; gi < READ_LAT; gi++) begin : g_stage
         imem_pipe_stage_t stage_reg;

         // Shift valid every cycle; capture payload only for a surviving word.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               stage_reg <= '0;
            end else begin
               stage_reg.valid <= pipe[gi-1].valid && !flush;
               if (pipe[gi-1].valid && !flush) begin
                  stage_reg.data <= pipe[gi-1].data;
                  stage_reg.npc  <= pipe[gi-1].npc;
               end
            end
         end

         assign pipe[gi] = stage_reg;

`ifdef IMEM_PARITY_EN
         logic bad_reg;

         // Parity status follows its word down the pipeline.
         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               bad_reg <= 1'b0;
            else if (pipe[gi-1].valid && !flush)
               bad_reg <= bad[gi-1];
         end

         assign bad[gi] = bad_reg;
`endif
      end
   endgenerate

   assign instr_valid = pipe[READ_LAT-1].valid;
   assign instr_dout  = pipe[READ_LAT-1].data;
   assign npc_out     = pipe[READ_LAT-1].npc;

`ifdef IMEM_PARITY_EN
   // Latch a parity mismatch seen on any returned valid word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         parity_err_reg <= 1'b0;
      else if (instr_valid && bad[READ_LAT-1])
         parity_err_reg <= 1'b1;
   end

   assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed plus randomized stimulus against a
// queue-based response model; every cycle's outputs are compared.
module tb_imem_fetch_responder;

   localparam int LAT = 3;
   localparam logic [15:0] BASE = 16'h3000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable_fetch = 1'b0;
   logic        Imem_rd = 1'b0;
   logic        flush = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] pc = '0;
   logic [15:0] npc = '0;
   logic [7:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        instr_valid;
   logic [15:0] instr_dout;
   logic [15:0] npc_out;
   logic [15:0] fetch_count;
   logic        addr_err;
   logic        npc_err;
   logic        seq_err;
`ifdef IMEM_PARITY_EN
   logic        parity_inject = 1'b0;
   logic        parity_err;
`endif

   always #5 clock = ~clock;

   imem_fetch_responder #(
      .BASE_ADDR (BASE),
      .DEPTH     (256),
      .READ_LAT  (LAT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable_fetch (enable_fetch),
      .pc           (pc),
      .npc          (npc),
      .Imem_rd      (Imem_rd),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
`ifdef IMEM_PARITY_EN
      .parity_inject(parity_inject),
      .parity_err   (parity_err),
`endif
      .instr_valid  (instr_valid),
      .instr_dout   (instr_dout),
      .npc_out      (npc_out),
      .fetch_count  (fetch_count),
      .addr_err     (addr_err),
      .npc_err      (npc_err),
      .seq_err      (seq_err)
   );

   typedef struct { int due; logic [15:0] data; logic [15:0] npc; } resp_t;
   typedef struct { int at_edge; logic [15:0] data; logic [15:0] npc; } seen_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_n = 0;

   logic [15:0] m_mem [256];
   resp_t       m_q[$];
   seen_t       seen_q[$];
   logic [15:0] m_last_d, m_last_n, m_count, m_prev_pc;
   logic        m_addr, m_npc, m_seq, m_prev_ok;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_last_d  = '0;
      m_last_n  = '0;
      m_count   = '0;
      m_prev_pc = '0;
      m_addr    = 1'b0;
      m_npc     = 1'b0;
      m_seq     = 1'b0;
      m_prev_ok = 1'b0;
   endtask

   // One clock: drive, let the edge happen, advance the model, compare at negedge.
   task automatic step(input logic en, input logic rd, input logic [15:0] p, input logic [15:0] n,
                       input logic fl, input logic we, input logic [7:0] wa, input logic [15:0] wd);
      logic [15:0] idx;
      logic        oob;
      logic        exp_v;
      resp_t       r;
      enable_fetch = en; Imem_rd = rd; pc = p; npc = n; flush = fl;
      wr_en = we; wr_addr = wa; wr_data = wd;
      @(posedge clock);
      edge_n++;
      if (fl)
         m_q.delete();
      if (en && rd) begin
         idx    = p - BASE;
         oob    = (idx >= 16'd256);
         r.due  = edge_n + LAT - 1;
         r.data = oob ? 16'h0000 : m_mem[idx[7:0]];
         r.npc  = n;
         m_q.push_back(r);
         m_count = m_count + 16'd1;
         if (oob) m_addr = 1'b1;
         if (n != p + 16'd1) m_npc = 1'b1;
         if (m_prev_ok && !fl && p != m_prev_pc + 16'd1) m_seq = 1'b1;
         m_prev_pc = p;
         m_prev_ok = 1'b1;
      end else if (fl) begin
         m_prev_ok = 1'b0;
      end
      if (we)
         m_mem[wa] = wd;
      @(negedge clock);
      exp_v = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == edge_n) begin
         exp_v    = 1'b1;
         m_last_d = m_q[0].data;
         m_last_n = m_q[0].npc;
         void'(m_q.pop_front());
      end
      chk1("instr_valid", instr_valid, exp_v);
      chk("instr_dout", instr_dout, m_last_d);
      chk("npc_out", npc_out, m_last_n);
      chk("fetch_count", fetch_count, m_count);
      chk1("addr_err", addr_err, m_addr);
      chk1("npc_err", npc_err, m_npc);
      chk1("seq_err", seq_err, m_seq);
      if (instr_valid === 1'b1)
         seen_q.push_back('{edge_n, instr_dout, npc_out});
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic req(input logic [15:0] p, input logic [15:0] n, input logic fl);
      step(1'b1, 1'b1, p, n, fl, 1'b0, 8'h00, 16'h0000);
   endtask

   // Called at a negedge: asynchronous reset must clear outputs without a clock.
   task automatic do_reset();
      enable_fetch = 0; Imem_rd = 0; flush = 0; wr_en = 0;
      reset = 1'b1;
      #1;
      model_reset();
      chk1("rst_valid", instr_valid, 1'b0);
      chk("rst_dout", instr_dout, 16'h0000);
      chk("rst_npc_out", npc_out, 16'h0000);
      chk("rst_count", fetch_count, 16'h0000);
      chk1("rst_addr_err", addr_err, 1'b0);
      chk1("rst_npc_err", npc_err, 1'b0);
      chk1("rst_seq_err", seq_err, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      seen_q.delete();
   endtask

   initial begin
      logic [15:0] words [4];
      int s;
      words = '{16'h1021, 16'h5020, 16'h0E02, 16'hF025};
      model_reset();
      @(negedge clock);
      do_reset();

      // Preload every word; fixed words at indices 0..3 and 16.
      for (int i = 0; i < 256; i++) begin
         logic [15:0] d;
         d = (i < 4) ? words[i] : ((i == 16) ? 16'h1234 : 16'($urandom));
         step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'(i), d);
      end

      // Four sequential fetches.
      seen_q.delete();
      s = edge_n;
      for (int i = 0; i < 4; i++)
         req(16'(BASE + 16'(i)), 16'(BASE + 16'(i + 1)), 1'b0);
      idle(LAT + 1);
      chk("t1_count", fetch_count, 16'd4);
      chk("t1_nresp", 16'(seen_q.size()), 16'd4);
      for (int i = 0; i < 4; i++) begin
         if (seen_q.size() > i) begin
            chk("t1_data", seen_q[i].data, words[i]);
            chk("t1_npc", seen_q[i].npc, 16'(BASE + 16'(i + 1)));
            chk("t1_when", 16'(seen_q[i].at_edge - s), 16'(i + LAT));
         end
      end
      chk1("t1_flags", addr_err | npc_err | seq_err, 1'b0);

      // Read strobe or enable alone is not a request.
      seen_q.delete();
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 16'h3004, 16'h3005, 1'b0, 1'b0, 8'h00, 16'h0000);
      step(1'b1, 1'b0, 16'h3004, 16'h3005, 1'b0, 1'b0, 8'h00, 16'h0000);
      idle(LAT);
      chk("t2_count", fetch_count, 16'd4);
      chk("t2_nresp", 16'(seen_q.size()), 16'd0);

      // Reset while one word is on the output and two are in flight.
      req(16'h3004, 16'h3005, 1'b0);
      req(16'h3005, 16'h3006, 1'b0);
      req(16'h3006, 16'h3007, 1'b0);
      chk1("t5_valid_before", instr_valid, 1'b1);
      do_reset();
      idle(LAT + 1);
      chk("t5_nresp", 16'(seen_q.size()), 16'd0);

      // Flush kills in-flight reads; only the flush-edge request returns.
      s = edge_n;
      req(16'h3000, 16'h3001, 1'b0);
      req(16'h3001, 16'h3002, 1'b0);
      req(16'h3010, 16'h3011, 1'b1);
      idle(LAT + 1);
      chk("t3_nresp", 16'(seen_q.size()), 16'd1);
      if (seen_q.size() > 0) begin
         chk("t3_data", seen_q[0].data, 16'h1234);
         chk("t3_when", 16'(seen_q[0].at_edge - s), 16'(LAT + 2));
      end
      chk1("t3_seq0", seq_err, 1'b0);
      req(16'h3005, 16'h3006, 1'b0);
      idle(1);
      chk1("t3_seq1", seq_err, 1'b1);
      chk1("t3_npc0", npc_err, 1'b0);

      // Out of range read, then a bad npc.
      do_reset();
      s = edge_n;
      req(16'h3100, 16'h3101, 1'b0);
      idle(LAT);
      chk1("t4_addr", addr_err, 1'b1);
      chk1("t4_npc0", npc_err, 1'b0);
      if (seen_q.size() > 0) begin
         chk("t4_data", seen_q[0].data, 16'h0000);
         chk("t4_when", 16'(seen_q[0].at_edge - s), 16'(LAT));
      end
      req(16'h3005, 16'h3007, 1'b1);
      idle(LAT);
      chk1("t4_npc1", npc_err, 1'b1);
      chk1("t4_seq0", seq_err, 1'b0);

      // 16-bit wrap of both the sequence and the npc checks.
      do_reset();
      req(16'hFFFF, 16'h0000, 1'b0);
      req(16'h0000, 16'h0001, 1'b0);
      idle(LAT);
      chk1("wrap_seq", seq_err, 1'b0);
      chk1("wrap_npc", npc_err, 1'b0);
      chk1("wrap_addr", addr_err, 1'b1);
      chk("wrap_count", fetch_count, 16'd2);

      // Random legal traffic: flags must stay clear; jumps only with flush.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic en, rd, fl, we;
         logic [15:0] p, n, wd;
         logic [7:0] wa;
         en = ($urandom_range(0, 9) < 8);
         rd = ($urandom_range(0, 9) < 8);
         fl = ($urandom_range(0, 11) == 0);
         if (en && rd) begin
            if (m_prev_ok && !fl && m_prev_pc != 16'h30FF) begin
               p = m_prev_pc + 16'd1;
            end else begin
               if (m_prev_ok) fl = 1'b1;
               p = BASE + 16'($urandom_range(0, 255));
            end
            n = p + 16'd1;
         end else begin
            p = 16'($urandom);
            n = 16'($urandom);
         end
         we = ($urandom_range(0, 3) == 0);
         wa = ($urandom_range(0, 1) == 1) ? 8'(p - BASE) : 8'($urandom);
         wd = 16'($urandom);
         step(en, rd, p, n, fl, we, wa, wd);
      end
      idle(LAT);

      // Random traffic with protocol violations.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic en, rd, fl, we;
         logic [15:0] p, n, wd;
         logic [7:0] wa;
         en = ($urandom_range(0, 9) < 8);
         rd = ($urandom_range(0, 9) < 8);
         fl = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0 || !m_prev_ok)
            p = 16'(BASE - 16'd4 + 16'($urandom_range(0, 263)));
         else
            p = m_prev_pc + 16'd1;
         n = ($urandom_range(0, 7) == 0) ? 16'($urandom) : p + 16'd1;
         we = ($urandom_range(0, 3) == 0);
         wa = 8'($urandom);
         wd = 16'($urandom);
         step(en, rd, p, n, fl, we, wa, wd);
      end
      idle(LAT);

`ifdef IMEM_PARITY_EN
      // A clean word keeps parity_err low; an injected one sets it.
      do_reset();
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd32, 16'h00F0);
      parity_inject = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd33, 16'h00FF);
      parity_inject = 1'b0;
      req(16'h3020, 16'h3021, 1'b0);
      idle(LAT + 1);
      chk1("par_clean", parity_err, 1'b0);
      req(16'h3021, 16'h3022, 1'b0);
      idle(LAT + 1);
      chk1("par_inject", parity_err, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
